// File: rtl/column_frame_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | column_frame_writer_pkg                                                    |
// | Shared frame geometry, column-word layout and writer state encoding.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package column_frame_writer_pkg;

    localparam int c_width = 640;
    localparam int c_height = 480;
    localparam int c_idx_w = 10;
    localparam int c_hgt_w = 9;
    localparam int c_lit_w = 2;
    localparam int c_tex_w = 4;

    typedef struct packed {
        logic [c_hgt_w-1:0] height;
        logic [c_lit_w-1:0] light;
        logic [c_tex_w-1:0] tex;
    } column_word_t;

    localparam int c_word_w = $bits(column_word_t);

    localparam logic [1:0] c_st_init      = 2'd0;
    localparam logic [1:0] c_st_fill      = 2'd1;
    localparam logic [1:0] c_st_wait_swap = 2'd2;

endpackage
`default_nettype wire

// File: rtl/column_bank_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | column_bank_ram                                                            |
// | One frame bank: single write port, registered read port (0 when out of     |
// | range).                                                                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module column_bank_ram
    import column_frame_writer_pkg::*;
#(
    parameter int DEPTH  = c_width,
    parameter int ADDR_W = c_idx_w,
    parameter int DATA_W = c_word_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam logic [ADDR_W:0] c_depth = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we && ({1'b0, i_waddr} < c_depth)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if ({1'b0, i_raddr} < c_depth) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/column_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | column_frame_writer                                                        |
// | Ping-pong per-column frame store; back bank filled in order, swapped at    |
// | vblank. Rev 1.0                                                            |
// +----------------------------------------------------------------------------+
module column_frame_writer
    import column_frame_writer_pkg::*;
#(
    parameter int WIDTH = c_width,
    parameter int IDX_W = c_idx_w,
    parameter int HGT_W = c_hgt_w,
    parameter int LIT_W = c_lit_w,
    parameter int TEX_W = c_tex_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_index,
    input  logic [HGT_W-1:0] in_height,
    input  logic [LIT_W-1:0] in_light,
    input  logic [TEX_W-1:0] in_tex,
    input  logic             vblank_start,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [HGT_W-1:0] rd_height,
    output logic [LIT_W-1:0] rd_light,
    output logic [TEX_W-1:0] rd_tex,
    output logic             write_new_frame,
    output logic             data_initialised,
    output logic             front_bank,
    output logic             seq_error
);

    localparam int c_wd_w = HGT_W + LIT_W + TEX_W;
    localparam logic [IDX_W-1:0] c_last = IDX_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_expected;
    logic             r_in_ready;
    logic             r_write_new_frame;
    logic             r_data_initialised;
    logic             r_front_bank;
    logic             r_seq_error;
    logic             r_rd_sel;

    logic              w_accept;
    logic              w_in_order;
    logic              w_we;
    logic              w_last;
    logic [c_wd_w-1:0] w_wdata;
    logic [c_wd_w-1:0] w_bank_rdata [2];

    assign w_accept   = in_valid && r_in_ready && (r_state != c_st_wait_swap);
    assign w_in_order = (in_index == r_expected);
    assign w_we       = w_accept && w_in_order;
    assign w_last     = w_we && (in_index == c_last);
    assign w_wdata    = {in_height, in_light, in_tex};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state            <= c_st_init;
            r_expected         <= '0;
            r_in_ready         <= 1'b1;
            r_write_new_frame  <= 1'b1;
            r_data_initialised <= 1'b0;
            r_front_bank       <= 1'b0;
            r_seq_error        <= 1'b0;
        end else begin
            if (w_accept && !w_in_order) begin
                r_seq_error <= 1'b1;
            end
            if (w_we) begin
                r_expected <= r_expected + 1'b1;
            end
            case (r_state)
                // First fill goes live immediately so the display has something to show.
                c_st_init: begin
                    if (w_last) begin
                        r_front_bank       <= 1'b1;
                        r_data_initialised <= 1'b1;
                        r_expected         <= '0;
                        r_state            <= c_st_fill;
                    end
                end
                c_st_fill: begin
                    if (w_last) begin
                        r_write_new_frame <= 1'b0;
                        r_in_ready        <= 1'b0;
                        r_state           <= c_st_wait_swap;
                    end
                end
                c_st_wait_swap: begin
                    if (vblank_start) begin
                        r_front_bank      <= ~r_front_bank;
                        r_expected        <= '0;
                        r_write_new_frame <= 1'b1;
                        r_in_ready        <= 1'b1;
                        r_state           <= c_st_fill;
                    end
                end
                default: r_state <= c_st_init;
            endcase
        end
    end

    // Read mux follows the bank select that was live when the RAM registered its data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_sel <= 1'b0;
        end else begin
            r_rd_sel <= r_front_bank;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        column_bank_ram #(
            .DEPTH  (WIDTH),
            .ADDR_W (IDX_W),
            .DATA_W (c_wd_w)
        ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .i_we    (w_we && (r_front_bank != 1'(b))),
            .i_waddr (in_index),
            .i_wdata (w_wdata),
            .i_raddr (rd_addr),
            .o_rdata (w_bank_rdata[b])
        );
    end

    assign {rd_height, rd_light, rd_tex} = w_bank_rdata[r_rd_sel];

    assign in_ready         = r_in_ready;
    assign write_new_frame  = r_write_new_frame;
    assign data_initialised = r_data_initialised;
    assign front_bank       = r_front_bank;
    assign seq_error        = r_seq_error;

endmodule
`default_nettype wire

// File: tb/tb_column_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_column_frame_writer                                                     |
// | Directed self-checking bench for the ping-pong column frame store.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_column_frame_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_index;
    logic [8:0] in_height;
    logic [1:0] in_light;
    logic [3:0] in_tex;
    logic       vblank_start;
    logic [9:0] rd_addr;
    logic [8:0] rd_height;
    logic [1:0] rd_light;
    logic [3:0] rd_tex;
    logic       write_new_frame;
    logic       data_initialised;
    logic       front_bank;
    logic       seq_error;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    column_frame_writer dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_index         (in_index),
        .in_height        (in_height),
        .in_light         (in_light),
        .in_tex           (in_tex),
        .vblank_start     (vblank_start),
        .rd_addr          (rd_addr),
        .rd_height        (rd_height),
        .rd_light         (rd_light),
        .rd_tex           (rd_tex),
        .write_new_frame  (write_new_frame),
        .data_initialised (data_initialised),
        .front_bank       (front_bank),
        .seq_error        (seq_error)
    );

    // Frame 2 uses the literal pattern height=index, light=2, tex=0xA.
    function automatic logic [8:0] pat_h(input int p, input int i);
        return (p == 2) ? 9'(i) : 9'(i + 123 * p);
    endfunction
    function automatic logic [1:0] pat_l(input int p);
        return 2'(p);
    endfunction
    function automatic logic [3:0] pat_t(input int p, input int i);
        return (p == 2) ? 4'hA : 4'(i + p);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int idx, input logic [8:0] h, input logic [1:0] l,
                        input logic [3:0] t, input logic vb);
        in_valid     = 1'b1;
        in_index     = 10'(idx);
        in_height    = h;
        in_light     = l;
        in_tex       = t;
        vblank_start = vb;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        vblank_start = 1'b0;
    endtask

    task automatic send_range(input int p, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            send(i, pat_h(p, i), pat_l(p), pat_t(p, i), 1'b0);
        end
    endtask

    task automatic pulse_vblank();
        vblank_start = 1'b1;
        @(posedge clk);
        #1;
        vblank_start = 1'b0;
    endtask

    task automatic read_check(input string tag, input int addr, input logic [8:0] eh,
                              input logic [1:0] el, input logic [3:0] et);
        rd_addr = 10'(addr);
        @(posedge clk);
        #1;
        check({tag, ".h"}, 32'(rd_height), 32'(eh));
        check({tag, ".l"}, 32'(rd_light), 32'(el));
        check({tag, ".t"}, 32'(rd_tex), 32'(et));
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_index = '0;
        in_height = '0;
        in_light = '0;
        in_tex = '0;
        vblank_start = 1'b0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.wnf", 32'(write_new_frame), 32'd1);
        check("rst.init", 32'(data_initialised), 32'd0);
        check("rst.front", 32'(front_bank), 32'd0);
        check("rst.seq", 32'(seq_error), 32'd0);
        check("rst.rd", {rd_height, rd_light, rd_tex}, 32'd0);
        reset = 1'b0;

        // First fill: bank 1 goes live without waiting for vblank.
        send_range(1, 0, 638);
        check("init.pre", 32'(data_initialised), 32'd0);
        send_range(1, 639, 639);
        check("init.done", 32'(data_initialised), 32'd1);
        check("init.front", 32'(front_bank), 32'd1);
        check("init.wnf", 32'(write_new_frame), 32'd1);
        check("init.ready", 32'(in_ready), 32'd1);
        read_check("init.rd5", 5, pat_h(1, 5), pat_l(1), pat_t(1, 5));
        read_check("init.rd639", 639, pat_h(1, 639), pat_l(1), pat_t(1, 639));
        read_check("init.rd700", 700, 9'd0, 2'd0, 4'd0);

        // Frame 2 with an early vblank at index 300 that must be ignored.
        send_range(2, 0, 299);
        pulse_vblank();
        check("early.front", 32'(front_bank), 32'd1);
        check("early.wnf", 32'(write_new_frame), 32'd1);
        read_check("early.rd100", 100, pat_h(1, 100), pat_l(1), pat_t(1, 100));
        send_range(2, 300, 639);
        check("f2.wnf", 32'(write_new_frame), 32'd0);
        check("f2.ready", 32'(in_ready), 32'd0);
        send(0, 9'h1FF, 2'd3, 4'hF, 1'b0);
        check("wait.ignored_seq", 32'(seq_error), 32'd0);
        check("wait.front", 32'(front_bank), 32'd1);
        pulse_vblank();
        check("swap.front", 32'(front_bank), 32'd0);
        check("swap.wnf", 32'(write_new_frame), 32'd1);
        check("swap.ready", 32'(in_ready), 32'd1);
        read_check("swap.rd100", 100, 9'd100, 2'd2, 4'hA);
        read_check("swap.rd639", 639, 9'd127, 2'd2, 4'hA);
        read_check("swap.rd0", 0, 9'd0, 2'd2, 4'hA);

        // Frame 3: out-of-order index is dropped and flagged.
        send_range(3, 0, 5);
        send(7, 9'h1FF, 2'd0, 4'hF, 1'b0);
        check("seq.flag", 32'(seq_error), 32'd1);
        send_range(3, 6, 638);
        // vblank coincident with the final column must not swap.
        send(639, pat_h(3, 639), pat_l(3), pat_t(3, 639), 1'b1);
        check("coinc.front", 32'(front_bank), 32'd0);
        check("coinc.wnf", 32'(write_new_frame), 32'd0);
        read_check("coinc.rd7", 7, 9'd7, 2'd2, 4'hA);
        pulse_vblank();
        check("coinc.swap", 32'(front_bank), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("coinc.once", 32'(front_bank), 32'd1);
        read_check("seq.rd7", 7, 9'h178, 2'd3, 4'hA);
        read_check("seq.rd6", 6, pat_h(3, 6), pat_l(3), pat_t(3, 6));
        check("seq.sticky", 32'(seq_error), 32'd1);

        // Reset in the middle of frame 4.
        send_range(0, 0, 399);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid.init", 32'(data_initialised), 32'd0);
        check("mid.front", 32'(front_bank), 32'd0);
        check("mid.ready", 32'(in_ready), 32'd1);
        check("mid.wnf", 32'(write_new_frame), 32'd1);
        check("mid.seq", 32'(seq_error), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
